// File: rtl/inpr_fifo_team1_pkg.sv
// Shared constants for the INPR input FIFO.
//   INPR_DATA_W    : default word width of the input device
//   INPR_EMPTY_PAT : value presented on out_INPR when no word is buffered
package inpr_fifo_team1_pkg;
  localparam int INPR_DATA_W = 8;
  localparam logic [INPR_DATA_W-1:0] INPR_EMPTY_PAT = {INPR_DATA_W{1'b1}};
endpackage

// File: rtl/inpr_fifo_team1_mem.sv
// Storage array for the INPR FIFO: DEPTH x DATA_W registers,
// one synchronous write port and one asynchronous read port.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module inpr_fifo_team1_mem
  import inpr_fifo_team1_pkg::*;
#(
  parameter int DATA_W = INPR_DATA_W,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inpr_fifo_team1.sv
// INPR/FGI input FIFO. Buffers up to DEPTH words from the input device and
// presents the head word (registered) plus FGI to the CPU, which pops with
// RST_FGI. Adds back-pressure (INPR_rdy), sticky overflow (OVF) and an
// IEN-gated interrupt request.
//   clk, RST        : clock, synchronous active-high reset
//   in_INPR/LD_INPR : device data / push strobe
//   INPR_rdy        : not full
//   out_INPR        : head word, all-ones when empty
//   FGI             : word available
//   RST_FGI         : pop head word
//   IEN / irq       : interrupt enable / FGI & IEN
//   OVF / CLR_OVF   : sticky dropped-push flag / clear
//   count           : words stored, 0..DEPTH
module inpr_fifo_team1
  import inpr_fifo_team1_pkg::*;
#(
  parameter int DATA_W = INPR_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [DATA_W-1:0]         in_INPR,
  input  logic                      LD_INPR,
  output logic                      INPR_rdy,
  output logic [DATA_W-1:0]         out_INPR,
  output logic                      FGI,
  input  logic                      RST_FGI,
  input  logic                      IEN,
  output logic                      irq,
  output logic                      OVF,
  input  logic                      CLR_OVF,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] EMPTY_PAT = {DATA_W{1'b1}};

  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]       count_nxt;
  logic              push, pop, drop;
  logic [DATA_W-1:0] head_rd;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is popped simultaneously.
  assign pop  = RST_FGI & FGI;
  assign push = LD_INPR & ((count != FULL_CNT) | pop);
  assign drop = LD_INPR & ~push;

  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  inpr_fifo_team1_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_INPR),
    .raddr (rd_ptr_nxt),
    .rdata (head_rd)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVF      <= 1'b0;
      out_INPR <= EMPTY_PAT;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // Set has priority over clear.
      if (drop)         OVF <= 1'b1;
      else if (CLR_OVF) OVF <= 1'b0;
      // When exactly one word remains after a push, that word is the one being
      // written this cycle; forward it because the array holds it only after
      // the edge.
      if (count_nxt == '0)                out_INPR <= EMPTY_PAT;
      else if (push && count_nxt == 1'b1) out_INPR <= in_INPR;
      else                                out_INPR <= head_rd;
    end
  end

  assign FGI      = (count != '0);
  assign INPR_rdy = (count != FULL_CNT);
  assign irq      = FGI & IEN;

endmodule
